// File: rtl/upstream_processor.sv
// upstream_processor
//   Buffers local write commands in a small FIFO and forwards them one at a
//   time to the downstream processor using a 4-phase memwr/ack handshake.
//   An attempt that sees no ack within TIMEOUT cycles is abandoned and
//   retried up to MAX_RETRY times; after that the entry is dropped and
//   counted as an error.
//
// Parameters
//   DEPTH      command FIFO entries (power of two, >= 2)
//   TIMEOUT    cycles in REQ without ack before an attempt is abandoned
//   MAX_RETRY  re-attempts after the first before an entry is dropped
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command push handshake (cmd_ready = not full)
//   cmd_addr, cmd_data    command payload
//   memwr                 registered write request to downstream
//   mem_addr, mem_data    registered payload of the in-flight entry
//   ack                   downstream acknowledge
//   busy                  FSM not idle or FIFO non-empty
//   done_count            completed writes (wraps)
//   err_count             dropped entries (saturates at 15)
//   err                   sticky drop flag
module upstream_processor #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       memwr,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  input  logic       ack,
  output logic       busy,
  output logic [7:0] done_count,
  output logic [3:0] err_count,
  output logic       err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX    = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE, RETRY} state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Command FIFO. The in-flight entry stays at the head until it completes
  // or is dropped, so a retry re-reads nothing and the FIFO order is kept.
  logic [15:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [15:0]   head;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign head      = fifo_mem[rptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= {cmd_addr, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end

  // Handshake FSM
  state_t        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          memwr_n, err_n;
  logic [7:0]    addr_n, data_n, done_n;
  logic [3:0]    errc_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tcnt       <= '0;
      rcnt       <= '0;
      memwr      <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      done_count <= '0;
      err_count  <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      rcnt       <= rcnt_n;
      memwr      <= memwr_n;
      mem_addr   <= addr_n;
      mem_data   <= data_n;
      done_count <= done_n;
      err_count  <= errc_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    rcnt_n  = rcnt;
    memwr_n = memwr;
    addr_n  = mem_addr;
    data_n  = mem_data;
    done_n  = done_count;
    errc_n  = err_count;
    err_n   = err;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          {addr_n, data_n} = head;
          tcnt_n  = '0;
          rcnt_n  = '0;
          memwr_n = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        // ack in the final timeout cycle still counts as success
        if (ack) begin
          memwr_n = 1'b0;
          pop     = 1'b1;
          done_n  = done_count + 8'd1;
          state_n = RELEASE;
        end else if (tcnt == T_LAST) begin
          memwr_n = 1'b0;
          if (rcnt < R_MAX) begin
            rcnt_n  = rcnt + RW'(1);
            state_n = RETRY;
          end else begin
            pop     = 1'b1;
            errc_n  = sat_inc4(err_count);
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      RETRY: begin
        // one idle cycle between attempts; payload registers are untouched
        tcnt_n  = '0;
        memwr_n = 1'b1;
        state_n = REQ;
      end
      RELEASE: begin
        if (!ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_upstream_processor.sv
// Testbench for upstream_processor: scoreboard of accepted commands checked
// by an independent monitor against the handshake rules, with an ack
// responder that picks per-attempt ack delays (random or scripted).
module tb_upstream_processor;
  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;
  localparam int NEVER     = 1000000;

  logic       clk, rst_n, cmd_valid, cmd_ready, memwr, ack, busy, err;
  logic [7:0] cmd_addr, cmd_data, mem_addr, mem_data, done_count;
  logic [3:0] err_count;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  int exp_done = 0;
  int exp_err = 0;
  int ack_mode = 2;   // 0 random delay, 1 never ack, 2 fixed delay
  int fixed_d = 1;
  int fixed_h = 0;
  int skip_n = 0;     // upcoming attempts left unacknowledged

  upstream_processor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .memwr(memwr), .mem_addr(mem_addr),
    .mem_data(mem_data), .ack(ack), .busy(busy), .done_count(done_count),
    .err_count(err_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Ack responder: waits for a new memwr pulse, acks after d cycles (or not
  // at all when d >= TIMEOUT), then holds ack h extra cycles after memwr drops.
  initial begin : responder
    int n, d, h;
    bit hi;
    ack = 1'b0; hi = 0; n = 0; d = 0; h = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack = 1'b0; hi = 0;
      end else if (ack) begin
        if (!memwr) begin
          if (h == 0) ack = 1'b0;
          else h--;
        end
      end else if (memwr) begin
        if (!hi) begin
          hi = 1; n = 0;
          if (skip_n > 0) begin skip_n--; d = NEVER; end
          else if (ack_mode == 0) d = $urandom_range(0, TIMEOUT + TIMEOUT / 2);
          else if (ack_mode == 1) d = NEVER;
          else d = fixed_d;
          h = (ack_mode == 0) ? $urandom_range(0, 2) : fixed_h;
        end else begin
          n++;
        end
        if (n == d) ack = 1'b1;
      end else begin
        hi = 0;
      end
    end
  end

  // Monitor: compares each memwr pulse against the head of the scoreboard
  // and checks attempt length, retry gap, payload stability and counters.
  initial begin : monitor
    logic pm;
    int hc, att;
    bit gap;
    logic [15:0] cur;
    pm = 1'b0; hc = 0; att = 0; gap = 0; cur = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pm = 1'b0; hc = 0; att = 0; gap = 0;
        exp_q.delete(); exp_done = 0; exp_err = 0;
      end else begin
        if (pm) begin
          if (ack) begin
            check("ack_fall", memwr, 0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_done++; att = 0; hc = 0;
            check("done_count", done_count, exp_done % 256);
            check("err_after_success", err, exp_err > 0);
          end else begin
            hc++;
            if (hc == TIMEOUT) begin
              check("timeout_fall", memwr, 0);
              hc = 0; att++;
              if (att > MAX_RETRY) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                exp_err++; att = 0;
                check("err_count", err_count, sat15(exp_err));
                check("err_flag", err, 1);
                check("done_after_drop", done_count, exp_done % 256);
              end else begin
                gap = 1;
              end
            end else begin
              check("hold_memwr", memwr, 1);
              check("hold_payload", {mem_addr, mem_data}, cur);
            end
          end
        end else if (memwr) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_write: got write %h expected no write at %0t", {mem_addr, mem_data}, $time);
          end else begin
            check("order", {mem_addr, mem_data}, exp_q[0]);
          end
          if (gap) check("retry_payload", {mem_addr, mem_data}, cur);
          cur = {mem_addr, mem_data}; gap = 0; hc = 0;
        end else if (gap) begin
          check("retry_gap", memwr, 1);
          gap = 0;
        end
        pm = memwr;
      end
    end
  end

  task automatic drive_cmd(input bit v, input logic [7:0] a, input logic [7:0] d, output bit acc);
    @(negedge clk);
    check("cmd_ready", cmd_ready, exp_q.size() < DEPTH);
    acc = v && (exp_q.size() < DEPTH);
    cmd_valid = v; cmd_addr = a; cmd_data = d;
    if (acc) exp_q.push_back({a, d});
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive_cmd(1'b0, 8'h00, 8'h00, acc);
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    bit acc;
    int got = 0;
    int tries = 0;
    while (got < n && tries < 4000) begin
      drive_cmd(1'b1, base + 8'(got), 8'($urandom), acc);
      if (acc) got++;
      tries++;
    end
    if (got < n) begin
      total++; bad++;
      $display("FAIL push_timeout: got %0d accepted expected %0d", got, n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() > 0 || memwr) && n < limit) begin
      idle(1);
      n++;
    end
    if (n >= limit) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    idle(6);
    check("busy_idle", busy, 0);
  endtask

  initial begin : main
    bit acc;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_memwr", memwr, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_addr_data", {mem_addr, mem_data}, 0);
    check("rst_counters", {done_count, err_count, err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // single write with first-rise latency
    ack_mode = 2; fixed_d = 2; fixed_h = 0;
    drive_cmd(1'b1, 8'h10, 8'hA5, acc);
    @(posedge clk); #1;
    check("lat_idle_cycle", memwr, 0);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_rise", memwr, 1);
    check("single_payload", {mem_addr, mem_data}, 16'h10A5);
    wait_drain(200);
    check("single_done", done_count, 1);

    // fill: 5 pushes with no ack, 5th refused, then drain in order
    ack_mode = 1;
    for (int i = 0; i < 5; i++) drive_cmd(1'b1, 8'h20 + 8'(i), 8'h50 + 8'(i), acc);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("fill_full", cmd_ready, 0);
    ack_mode = 2; fixed_d = 3; fixed_h = 1;
    wait_drain(1000);
    check("fill_done", done_count, 5);

    // retry then succeed
    skip_n = 1; fixed_d = 4;
    push_n(1, 8'h33);
    wait_drain(500);
    check("retry_done", done_count, 6);
    check("retry_no_err", {err_count, err}, 0);

    // drop after 1 + MAX_RETRY attempts, next entry still served
    skip_n = MAX_RETRY + 1; fixed_d = 2;
    push_n(2, 8'h77);
    wait_drain(1000);
    check("drop_err_count", err_count, 1);
    check("drop_err", err, 1);
    check("drop_done", done_count, 7);

    // ack in the very last cycle of the timeout window
    fixed_d = TIMEOUT - 1; fixed_h = 0;
    push_n(1, 8'h5C);
    wait_drain(500);
    check("boundary_done", done_count, 8);
    check("boundary_err_count", err_count, 1);

    // randomized traffic
    ack_mode = 0;
    for (int i = 0; i < 300; i++)
      drive_cmd(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), acc);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_drain(3000);

    // done_count wrap
    ack_mode = 2; fixed_d = 0; fixed_h = 0;
    push_n(256 - (exp_done % 256), 8'h00);
    wait_drain(2000);
    check("done_wrap", done_count, 0);

    // err_count saturation
    ack_mode = 1;
    push_n(16, 8'h60);
    wait_drain(2500);
    check("err_saturate", err_count, 15);
    check("err_sticky", err, 1);

    // asynchronous reset mid-request with entries queued
    push_n(4, 8'hC0);
    idle(3);
    check("pre_rst_memwr", memwr, 1);
    check("pre_rst_full", cmd_ready, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_memwr", memwr, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_addr_data", {mem_addr, mem_data}, 0);
    check("midrst_counters", {done_count, err_count, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("postrst_memwr", memwr, 0);
    check("postrst_busy", busy, 0);

    // function resumes after reset
    ack_mode = 2; fixed_d = 1;
    push_n(1, 8'hE1);
    wait_drain(200);
    check("postrst_done", done_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
